// File: rtl/ping_pong_wr_ctrl_if.sv
// Stream-in / dual-bank RAM write bus of the ping-pong write controller.
// s_axis_tlast exists only when PPB_TLAST_EN is defined.
interface ping_pong_wr_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRW      = 4
);
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
`ifdef PPB_TLAST_EN
    logic                  s_axis_tlast;
`endif
    logic [1:0]            ram_ena;
    logic                  ram_wea;
    logic [ADDRW-1:0]      ram_addra;
    logic [DATA_WIDTH-1:0] ram_dia;
    logic [1:0]            bank_full;
    logic [ADDRW:0]        bank_len0;
    logic [ADDRW:0]        bank_len1;
    logic [1:0]            rd_release;
    logic                  wr_bank;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, rd_release,
`ifdef PPB_TLAST_EN
        input  s_axis_tlast,
`endif
        output s_axis_tready, ram_ena, ram_wea, ram_addra, ram_dia,
        output bank_full, bank_len0, bank_len1, wr_bank
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, rd_release,
`ifdef PPB_TLAST_EN
        output s_axis_tlast,
`endif
        input  s_axis_tready, ram_ena, ram_wea, ram_addra, ram_dia,
        input  bank_full, bank_len0, bank_len1, wr_bank
    );
endinterface

// File: rtl/ping_pong_wr_ctrl.sv
// Ping-pong write controller: fills two RAM banks alternately from a stream.
// Define PPB_TLAST_EN to let s_axis_tlast close a bank before DEPTH words.
module ping_pong_wr_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDRW      = 4
) (
    input  logic               clk,
    input  logic               resetn,
    ping_pong_wr_ctrl_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_e;

    localparam logic [ADDRW-1:0] ADDR_LAST = ADDRW'(DEPTH - 1);

    bank_st_e              bank_q   [2];
    bank_st_e              bank_d   [2];
    logic [ADDRW:0]        len_q    [2];
    logic [ADDRW:0]        len_d    [2];
    logic                  wr_bank_q, wr_bank_d;
    logic [ADDRW-1:0]      addr_q, addr_d;
    // Write stage: the accepted beat one cycle later, plus its close info
    logic                  stg_vld_q, stg_vld_d;
    logic                  stg_bank_q, stg_bank_d;
    logic                  stg_close_q, stg_close_d;
    logic [ADDRW-1:0]      stg_addr_q, stg_addr_d;
    logic [DATA_WIDTH-1:0] stg_data_q, stg_data_d;
    logic [ADDRW:0]        stg_len_q, stg_len_d;

    logic tready, accept, last_beat;

    assign tready = resetn && (bank_q[wr_bank_q] != FULL);
    assign accept = bus.s_axis_tvalid && tready;
`ifdef PPB_TLAST_EN
    assign last_beat = (addr_q == ADDR_LAST) || bus.s_axis_tlast;
`else
    assign last_beat = (addr_q == ADDR_LAST);
`endif

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_d[b] = bank_q[b];
            len_d[b]  = len_q[b];
        end
        wr_bank_d   = wr_bank_q;
        addr_d      = addr_q;
        stg_vld_d   = accept;
        stg_bank_d  = stg_bank_q;
        stg_close_d = stg_close_q;
        stg_addr_d  = stg_addr_q;
        stg_data_d  = stg_data_q;
        stg_len_d   = stg_len_q;

        if (accept) begin
            stg_bank_d  = wr_bank_q;
            stg_close_d = last_beat;
            stg_addr_d  = addr_q;
            stg_data_d  = bus.s_axis_tdata;
            stg_len_d   = {1'b0, addr_q} + (ADDRW+1)'(1);
            addr_d      = last_beat ? '0 : addr_q + ADDRW'(1);
            wr_bank_d   = wr_bank_q ^ last_beat;
        end

        // A closing bank is never FULL, so release and close never collide
        for (int b = 0; b < 2; b++) begin
            if (bus.rd_release[b] && bank_q[b] == FULL) begin
                bank_d[b] = EMPTY;
                len_d[b]  = '0;
            end
            if (stg_vld_q && stg_close_q && stg_bank_q == 1'(b)) begin
                bank_d[b] = FULL;
                len_d[b]  = stg_len_q;
            end else if (accept && wr_bank_q == 1'(b) && bank_q[b] == EMPTY) begin
                bank_d[b] = FILLING;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bank_q[0]   <= EMPTY;
            bank_q[1]   <= EMPTY;
            len_q[0]    <= '0;
            len_q[1]    <= '0;
            wr_bank_q   <= 1'b0;
            addr_q      <= '0;
            stg_vld_q   <= 1'b0;
            stg_bank_q  <= 1'b0;
            stg_close_q <= 1'b0;
            stg_addr_q  <= '0;
            stg_data_q  <= '0;
            stg_len_q   <= '0;
        end else begin
            bank_q[0]   <= bank_d[0];
            bank_q[1]   <= bank_d[1];
            len_q[0]    <= len_d[0];
            len_q[1]    <= len_d[1];
            wr_bank_q   <= wr_bank_d;
            addr_q      <= addr_d;
            stg_vld_q   <= stg_vld_d;
            stg_bank_q  <= stg_bank_d;
            stg_close_q <= stg_close_d;
            stg_addr_q  <= stg_addr_d;
            stg_data_q  <= stg_data_d;
            stg_len_q   <= stg_len_d;
        end
    end

    assign bus.s_axis_tready = tready;
    assign bus.ram_ena       = !stg_vld_q ? 2'b00 : (stg_bank_q ? 2'b10 : 2'b01);
    assign bus.ram_wea       = stg_vld_q;
    assign bus.ram_addra     = stg_addr_q;
    assign bus.ram_dia       = stg_data_q;
    assign bus.bank_full     = {bank_q[1] == FULL, bank_q[0] == FULL};
    assign bus.bank_len0     = len_q[0];
    assign bus.bank_len1     = len_q[1];
    assign bus.wr_bank       = wr_bank_q;
endmodule

// File: tb/tb_ping_pong_wr_ctrl.sv
// Bench for ping_pong_wr_ctrl: directed vector table, reset/tlast sequences,
// then random traffic against a frame-level reference model.
module tb_ping_pong_wr_ctrl;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ping_pong_wr_ctrl_if #(.DATA_WIDTH(DW), .ADDRW(AW)) bus ();

    ping_pong_wr_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDRW(AW)) dut (
        .clk    (clk),
        .resetn (rstn),
        .bus    (bus.slave)
    );

    typedef struct {
        logic          rstn;
        logic          vld;
        logic [DW-1:0] data;
        logic [1:0]    rel;
        logic          tl;
        bit            ck;
        logic          rdy;
        logic [1:0]    full;
        logic          wb;
        logic [1:0]    ena;
        logic [AW-1:0] addr;
        bit            ck_len;
        logic [AW:0]   len0;
    } vec_t;

    vec_t vecs[$];
    int nchk = 0;
    int nerr = 0;

    // Reference model: bank full flags/lengths, fill position, pending write
    bit            m_full [2];
    int            m_len  [2];
    bit            m_bank;
    int            m_cnt;
    bit            m_pv, m_pb, m_pc;
    int            m_pa, m_pl;
    logic [DW-1:0] m_pd;

    function automatic vec_t mk(logic r, logic v, logic [DW-1:0] d, logic [1:0] rel, logic tl,
                                bit ck, logic rdy, logic [1:0] full, logic wb,
                                logic [1:0] ena, logic [AW-1:0] addr);
        vec_t x;
        x.rstn = r; x.vld = v; x.data = d; x.rel = rel; x.tl = tl;
        x.ck = ck; x.rdy = rdy; x.full = full; x.wb = wb; x.ena = ena; x.addr = addr;
        x.ck_len = 0; x.len0 = '0;
        return x;
    endfunction

    function automatic vec_t stim(logic r, logic v, logic [DW-1:0] d, logic [1:0] rel, logic tl);
        return mk(r, v, d, rel, tl, 0, 0, 2'b00, 0, 2'b00, '0);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_full[0] = 0; m_full[1] = 0; m_len[0] = 0; m_len[1] = 0;
        m_bank = 0; m_cnt = 0; m_pv = 0; m_pb = 0; m_pc = 0; m_pa = 0; m_pl = 0; m_pd = '0;
    endtask

    task automatic model_eval(input vec_t v);
        bit rdy, close;
        logic [1:0] eena;
        if (!v.rstn) model_clear();
        rdy  = v.rstn && !m_full[m_bank];
        eena = !m_pv ? 2'b00 : (m_pb ? 2'b10 : 2'b01);
        chk("m_tready", bus.s_axis_tready, rdy);
        chk("m_wr_bank", bus.wr_bank, m_bank);
        chk("m_bank_full", bus.bank_full, {m_full[1], m_full[0]});
        chk("m_ram_ena", bus.ram_ena, eena);
        chk("m_ram_wea", bus.ram_wea, m_pv);
        if (m_pv) begin
            chk("m_ram_addra", bus.ram_addra, 64'(m_pa));
            chk("m_ram_dia", bus.ram_dia, m_pd);
        end
        if (m_full[0] || !v.rstn) chk("m_bank_len0", bus.bank_len0, 64'(m_len[0]));
        if (m_full[1] || !v.rstn) chk("m_bank_len1", bus.bank_len1, 64'(m_len[1]));
        if (!v.rstn) return;
        for (int b = 0; b < 2; b++)
            if (v.rel[b] && m_full[b]) begin m_full[b] = 0; m_len[b] = 0; end
        if (m_pv && m_pc) begin m_full[m_pb] = 1; m_len[m_pb] = m_pl; end
        if (v.vld && rdy) begin
            close = (m_cnt == DEPTH - 1);
`ifdef PPB_TLAST_EN
            close = close || v.tl;
`endif
            m_pv = 1; m_pb = m_bank; m_pa = m_cnt; m_pd = v.data; m_pc = close; m_pl = m_cnt + 1;
            if (close) begin m_cnt = 0; m_bank = !m_bank; end
            else m_cnt = m_cnt + 1;
        end else begin
            m_pv = 0;
        end
    endtask

    task automatic run_cycle(input vec_t v);
        rstn = v.rstn;
        bus.s_axis_tvalid = v.vld;
        bus.s_axis_tdata  = v.data;
        bus.rd_release    = v.rel;
`ifdef PPB_TLAST_EN
        bus.s_axis_tlast  = v.tl;
`endif
        @(negedge clk);
        if (v.ck) begin
            chk("v_tready", bus.s_axis_tready, v.rdy);
            chk("v_bank_full", bus.bank_full, v.full);
            chk("v_wr_bank", bus.wr_bank, v.wb);
            chk("v_ram_ena", bus.ram_ena, v.ena);
            if (v.ena != 2'b00) chk("v_ram_addra", bus.ram_addra, v.addr);
        end
        if (v.ck_len) chk("v_bank_len0", bus.bank_len0, v.len0);
        if (!v.rstn) begin
            chk("rst_outputs", {bus.s_axis_tready, bus.ram_ena, bus.ram_wea, bus.ram_addra,
                                bus.bank_full, bus.bank_len0, bus.bank_len1, bus.wr_bank}, '0);
            chk("rst_ram_dia", bus.ram_dia, '0);
        end
        model_eval(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        bus.s_axis_tvalid = 0; bus.s_axis_tdata = '0; bus.rd_release = '0;
`ifdef PPB_TLAST_EN
        bus.s_axis_tlast = 0;
`endif
        model_clear();

        // Directed table: fill bank 0, fill bank 1 with an ignored release, stall, release
        for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 0, '0, 2'b00, 0, 1, 0, 2'b00, 0, 2'b00, '0));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(1, 1, DW'(i), 2'b00, 0, 1, 1, 2'b00, 0,
                              (i != 0) ? 2'b01 : 2'b00, AW'(i - 1)));
        vecs.push_back(mk(1, 0, '0, 2'b00, 0, 1, 1, 2'b00, 1, 2'b01, AW'(15)));
        v = mk(1, 0, '0, 2'b00, 0, 1, 1, 2'b01, 1, 2'b00, '0);
        v.ck_len = 1; v.len0 = 5'd16;
        vecs.push_back(v);
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(1, 1, DW'(16 + i), (i == 2) ? 2'b10 : 2'b00, 0, 1, 1, 2'b01, 1,
                              (i != 0) ? 2'b10 : 2'b00, AW'(i - 1)));
        vecs.push_back(mk(1, 1, DW'(32), 2'b00, 0, 1, 0, 2'b01, 0, 2'b10, AW'(15)));
        vecs.push_back(mk(1, 1, DW'(32), 2'b00, 0, 1, 0, 2'b11, 0, 2'b00, '0));
        vecs.push_back(mk(1, 1, DW'(32), 2'b01, 0, 1, 0, 2'b11, 0, 2'b00, '0));
        vecs.push_back(mk(1, 1, DW'(32), 2'b00, 0, 1, 1, 2'b10, 0, 2'b00, '0));
        vecs.push_back(mk(1, 0, '0, 2'b00, 0, 1, 1, 2'b10, 0, 2'b01, '0));

        @(posedge clk); #1;
        foreach (vecs[i]) run_cycle(vecs[i]);

        // Reset in the middle of bank 1, then resume at bank 0 address 0
        run_cycle(stim(0, 0, '0, 2'b00, 0));
        for (int i = 0; i < 23; i++) run_cycle(stim(1, 1, DW'(100 + i), 2'b00, 0));
        run_cycle(stim(0, 1, DW'(200), 2'b00, 0));
        run_cycle(stim(0, 0, '0, 2'b00, 0));
        run_cycle(stim(1, 1, DW'(32'hABC), 2'b00, 0));
        run_cycle(mk(1, 0, '0, 2'b00, 0, 1, 1, 2'b00, 0, 2'b01, '0));
        chk("resume_dia", bus.ram_dia, 32'hABC);

`ifdef PPB_TLAST_EN
        // Short frame closed by tlast on the fifth beat
        run_cycle(stim(0, 0, '0, 2'b00, 0));
        for (int i = 0; i < 5; i++) run_cycle(stim(1, 1, DW'(i), 2'b00, i == 4));
        run_cycle(mk(1, 1, DW'(77), 2'b00, 0, 1, 1, 2'b00, 1, 2'b01, AW'(4)));
        v = mk(1, 0, '0, 2'b00, 0, 1, 1, 2'b01, 1, 2'b10, '0);
        v.ck_len = 1; v.len0 = 5'd5;
        run_cycle(v);
`endif

        // Random traffic with sporadic releases and resets
        run_cycle(stim(0, 0, '0, 2'b00, 0));
        for (int i = 0; i < 3000; i++)
            run_cycle(stim($urandom_range(0, 499) != 0, $urandom_range(0, 9) < 7, $urandom,
                           {$urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0},
                           $urandom_range(0, 15) == 0));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
